button_event_ctrl: RTL and testbench

BUTTON_EVENT_CTRL -- requirements
Module: button_event_ctrl

---
 rtl/btn_evt_pkg.sv | 9 +
 rtl/button_event_ctrl_evt_fifo.sv | 40 ++++
 rtl/button_event_ctrl.sv | 141 ++++++++++++++
 tb/tb_button_event_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/btn_evt_pkg.sv
// btn_evt_pkg: shared event codes, per-button state type and FIFO depth
package btn_evt_pkg;
  localparam logic [1:0] EVT_PRESS   = 2'd0;
  localparam logic [1:0] EVT_RELEASE = 2'd1;
  localparam logic [1:0] EVT_LONG    = 2'd2;
  localparam logic [1:0] EVT_REPEAT  = 2'd3;
  localparam int FIFO_DEPTH = 4;
  typedef enum logic [1:0] {ST_IDLE, ST_PRESSED, ST_HELD} btn_state_e;
endpackage

// File: rtl/button_event_ctrl_evt_fifo.sv
// evt_fifo: synchronous FIFO; a pop frees the entry a same-cycle push uses when full
module evt_fifo
  import btn_evt_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign empty   = cnt_q == '0;
  assign full    = cnt_q == (AW+1)'(FIFO_DEPTH);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem_q[rd_q];
  // storage is never read while empty, so it needs no reset
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= din;
  // read/write pointers and occupancy
  always_ff @(posedge clk)
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/button_event_ctrl.sv
// button_event_ctrl: per-button press/release/long/repeat detection, round-robin into an event FIFO
module button_event_ctrl
  import btn_evt_pkg::*;
#(
  parameter int          NUM_BUTTONS   = 4,
  parameter logic [23:0] LONG_CYCLES   = 24'd12_000_000,
  parameter logic [23:0] REPEAT_CYCLES = 24'd3_000_000,
  parameter bit          ACTIVE_LOW    = 1'b0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_BUTTONS-1:0]         btn,
  output logic                           evt_valid,
  input  logic                           evt_ready,
  output logic [1:0]                     evt_code,
  output logic [$clog2(NUM_BUTTONS)-1:0] evt_index,
  output logic [NUM_BUTTONS-1:0]         pressed,
  output logic                           overflow
);
  localparam int IW = $clog2(NUM_BUTTONS);
  logic [NUM_BUTTONS-1:0] lvl, pend_v, grant, drop;
  logic [NUM_BUTTONS-1:0][1:0] pend_c;
  logic [NUM_BUTTONS-1:0] pressed_q;
  logic [IW-1:0] ptr_q, ptr_d, gidx;
  logic found, can_push, fifo_empty, fifo_full, overflow_q;
  logic [IW+1:0] fifo_dout;
  assign lvl = ACTIVE_LOW ? ~btn : btn;
  genvar g;
  for (g = 0; g < NUM_BUTTONS; g++) begin : g_btn
    btn_state_e state_q, state_d;
    logic [23:0] cnt_q, cnt_d;
    logic ev_v, pv_q;
    logic [1:0] ev_c, pc_q;
    // release is checked first so it wins over a long/repeat in the same cycle
    always_comb begin
      state_d = state_q;
      cnt_d = cnt_q + 24'd1;
      ev_v = 1'b0;
      ev_c = EVT_PRESS;
      case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          if (lvl[g]) begin
            state_d = ST_PRESSED;
            ev_v = 1'b1;
          end
        end
        ST_PRESSED:
          if (!lvl[g]) begin
            state_d = ST_IDLE;
            cnt_d = '0;
            ev_v = 1'b1;
            ev_c = EVT_RELEASE;
          end else if (cnt_q == LONG_CYCLES - 24'd1) begin
            state_d = ST_HELD;
            cnt_d = '0;
            ev_v = 1'b1;
            ev_c = EVT_LONG;
          end
        ST_HELD:
          if (!lvl[g]) begin
            state_d = ST_IDLE;
            cnt_d = '0;
            ev_v = 1'b1;
            ev_c = EVT_RELEASE;
          end else if (cnt_q == REPEAT_CYCLES - 24'd1) begin
            cnt_d = '0;
            ev_v = 1'b1;
            ev_c = EVT_REPEAT;
          end
        default: begin
          state_d = ST_IDLE;
          cnt_d = '0;
        end
      endcase
    end
    // button FSM plus its single pending slot; a grant frees the slot for a same-cycle event
    always_ff @(posedge clk)
      if (rst) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        pv_q    <= 1'b0;
        pc_q    <= EVT_PRESS;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        if (ev_v && (!pv_q || grant[g])) begin
          pv_q <= 1'b1;
          pc_q <= ev_c;
        end else if (grant[g]) pv_q <= 1'b0;
      end
    assign pend_v[g] = pv_q;
    assign pend_c[g] = pc_q;
    assign drop[g]   = ev_v & pv_q & ~grant[g];
  end
  // a full FIFO can still take a word when the head is being popped this cycle
  assign can_push = ~fifo_full | evt_ready;
  // round-robin search starting at the pointer; first pending slot wins
  always_comb begin
    found = 1'b0;
    gidx = '0;
    grant = '0;
    for (int k = 0; k < NUM_BUTTONS; k++) begin
      int j;
      j = int'(ptr_q) + k;
      if (j >= NUM_BUTTONS) j = j - NUM_BUTTONS;
      if (!found && can_push && pend_v[j]) begin
        found = 1'b1;
        gidx = IW'(j);
        grant[j] = 1'b1;
      end
    end
    ptr_d = !found ? ptr_q : gidx == IW'(NUM_BUTTONS - 1) ? '0 : gidx + IW'(1);
  end
  // pointer, sticky overflow and registered pressed levels
  always_ff @(posedge clk)
    if (rst) begin
      ptr_q      <= '0;
      overflow_q <= 1'b0;
      pressed_q  <= '0;
    end else begin
      ptr_q      <= ptr_d;
      overflow_q <= overflow_q | (|drop);
      pressed_q  <= lvl;
    end
  evt_fifo #(.W(IW + 2)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (found),
    .pop  (evt_ready),
    .din  ({pend_c[gidx], gidx}),
    .dout (fifo_dout),
    .empty(fifo_empty),
    .full (fifo_full)
  );
  assign evt_valid = ~fifo_empty;
  assign evt_code  = fifo_dout[IW+:2];
  assign evt_index = fifo_dout[IW-1:0];
  assign pressed   = pressed_q;
  assign overflow  = overflow_q;
endmodule

// File: tb/tb_button_event_ctrl.sv
// tb_button_event_ctrl: directed and random stimulus against a hold-time based event model with a scoreboard
module tb_button_event_ctrl;
  localparam int N = 4;
  localparam int LC = 8;
  localparam int RC = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic evt_ready = 1'b0;
  logic [N-1:0] btn = '0;
  logic evt_valid, overflow;
  logic [1:0] evt_code;
  logic [1:0] evt_index;
  logic [N-1:0] pressed;
  int total = 0;
  int bad = 0;
  typedef struct {int code; int idx;} word_t;
  word_t sb[$];
  bit m_down[N];
  int m_age[N];
  bit m_pv[N];
  int m_pc[N];
  int m_cnt = 0;
  int m_ptr = 0;
  bit m_ovf = 0;
  logic [N-1:0] m_pressed = '0;

  button_event_ctrl #(
    .NUM_BUTTONS(N), .LONG_CYCLES(24'd8), .REPEAT_CYCLES(24'd4), .ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .btn(btn), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_code(evt_code), .evt_index(evt_index), .pressed(pressed), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int ev[N];
    int g;
    bit can, pop;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_down[i] = 0; m_age[i] = 0; m_pv[i] = 0; m_pc[i] = 0;
      end
      m_cnt = 0; m_ptr = 0; m_ovf = 0; m_pressed = '0;
      sb.delete();
      return;
    end
    for (int i = 0; i < N; i++) begin
      ev[i] = -1;
      if (!m_down[i] && btn[i]) begin
        m_down[i] = 1; m_age[i] = 0; ev[i] = 0;
      end else if (m_down[i] && !btn[i]) begin
        m_down[i] = 0; ev[i] = 1;
      end else if (m_down[i]) begin
        m_age[i]++;
        if (m_age[i] == LC) ev[i] = 2;
        else if (m_age[i] > LC && (m_age[i] - LC) % RC == 0) ev[i] = 3;
      end
    end
    can = (m_cnt < 4) || evt_ready;
    pop = (m_cnt > 0) && evt_ready;
    g = -1;
    if (can)
      for (int k = 0; k < N; k++)
        if (g < 0 && m_pv[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    if (pop) m_cnt--;
    if (g >= 0) begin
      sb.push_back('{m_pc[g], g});
      m_cnt++;
      m_pv[g] = 0;
      m_ptr = (g + 1) % N;
    end
    for (int i = 0; i < N; i++)
      if (ev[i] >= 0) begin
        if (m_pv[i]) m_ovf = 1;
        else begin
          m_pv[i] = 1; m_pc[i] = ev[i];
        end
      end
    m_pressed = btn;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial begin
    word_t w;
    forever begin
      @(negedge clk);
      check("evt_valid", int'(evt_valid), int'(m_cnt > 0));
      check("overflow", int'(overflow), int'(m_ovf));
      check("pressed", int'(pressed), int'(m_pressed));
      if (evt_valid && evt_ready) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_word: got code=%0d idx=%0d expected none at %0t", evt_code, evt_index, $time);
        end else begin
          w = sb.pop_front();
          check("evt_code", int'(evt_code), w.code);
          check("evt_index", int'(evt_index), w.idx);
        end
      end
    end
  end

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic check_word(string name, int code, int idx);
    check({name, "_valid"}, int'(evt_valid), 1);
    check({name, "_code"}, int'(evt_code), code);
    check({name, "_idx"}, int'(evt_index), idx);
  endtask

  initial begin
    evt_ready = 1'b1;
    step(3);
    check("rst_valid", int'(evt_valid), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_pressed", int'(pressed), 0);
    check("rst_code", int'(evt_code), 0);
    check("rst_index", int'(evt_index), 0);
    rst = 1'b0;
    step(2);
    btn = 4'b0100;
    step();
    check("t1_press_lat1", int'(evt_valid), 0);
    step();
    check_word("t1_press", 0, 2);
    step(3);
    btn = 4'b0000;
    step();
    check("t1_rel_lat1", int'(evt_valid), 0);
    step();
    check_word("t1_release", 1, 2);
    step(4);
    btn = 4'b0010;
    step(20);
    btn = 4'b0000;
    step(6);
    rst = 1'b1;
    step();
    rst = 1'b0;
    btn = 4'b1001;
    step(2);
    check_word("t3_first", 0, 0);
    step();
    check_word("t3_second", 0, 3);
    step(3);
    btn = 4'b0000;
    step(6);
    evt_ready = 1'b0;
    btn = 4'b1111;
    step(7);
    btn = 4'b0000;
    step(2);
    check("t4_no_ovf", int'(overflow), 0);
    btn = 4'b0001;
    step();
    check("t4_ovf", int'(overflow), 1);
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
    check("t5_still_full", int'(evt_valid), 1);
    step(2);
    evt_ready = 1'b1;
    btn = 4'b0000;
    step(14);
    evt_ready = 1'b0;
    btn = 4'b0010;
    step(12);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_valid", int'(evt_valid), 0);
    check("t6_overflow", int'(overflow), 0);
    evt_ready = 1'b1;
    step(2);
    check_word("t6_press", 0, 1);
    btn = 4'b0000;
    step(4);
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 15) == 0) btn[b] = ~btn[b];
      evt_ready = ((c / 200) % 4 == 3) ? 1'b0 : ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 1'b0;
    btn = '0;
    evt_ready = 1'b1;
    step(30);
    check("drain_sb_left", sb.size(), 0);
    check("drain_valid", int'(evt_valid), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
